// File: rtl/dcache_pkg.sv
// Shared widths and state encoding for the direct-mapped, write-through data cache controller.
package dcache_pkg;

   localparam int DC_ADDR_W   = 10;
   localparam int DC_INDEX_W  = 4;
   localparam int DC_OFFSET_W = 2;
   localparam int DC_TAG_W    = DC_ADDR_W - DC_INDEX_W - DC_OFFSET_W;
   localparam int DC_LINES    = 1 << DC_INDEX_W;

   localparam logic [1:0] ST_IDLE      = 2'd0;
   localparam logic [1:0] ST_READ_MISS = 2'd1;
   localparam logic [1:0] ST_WRITE_MEM = 2'd2;

   typedef enum logic [1:0] {
      IDLE      = ST_IDLE,
      READ_MISS = ST_READ_MISS,
      WRITE_MEM = ST_WRITE_MEM
   } dc_state_t;

endpackage

// File: rtl/dcache_controller_if.sv
// Core load/store control, data-array write port and main-memory port of the data cache.
interface dcache_controller_if
   import dcache_pkg::*;
#(
   parameter int ADDR_W   = DC_ADDR_W,
   parameter int INDEX_W  = DC_INDEX_W,
   parameter int OFFSET_W = DC_OFFSET_W
);
   logic                cpu_rd;
   logic                cpu_wr;
   logic [ADDR_W-1:0]   cpu_addr;
   logic                stall;
   logic                hit;
   logic                arr_we;
   logic [INDEX_W-1:0]  arr_index;
   logic [OFFSET_W-1:0] arr_offset;
   logic                arr_src;
   logic                mem_req;
   logic                mem_we;
   logic [ADDR_W-1:0]   mem_addr;
   logic                mem_ack;

   // master: core + memory side; slave: the cache controller
   modport master (
      output cpu_rd, cpu_wr, cpu_addr, mem_ack,
      input  stall, hit, arr_we, arr_index, arr_offset, arr_src,
             mem_req, mem_we, mem_addr
   );

   modport slave (
      input  cpu_rd, cpu_wr, cpu_addr, mem_ack,
      output stall, hit, arr_we, arr_index, arr_offset, arr_src,
             mem_req, mem_we, mem_addr
   );

endinterface

// File: rtl/dcache_tag_store.sv
// Tag/valid array: combinational lookup, registered line install, async clear of valid bits.
module dcache_tag_store
   import dcache_pkg::*;
#(
   parameter int INDEX_W = DC_INDEX_W,
   parameter int TAG_W   = DC_TAG_W
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [INDEX_W-1:0] rd_index,
   input  logic [TAG_W-1:0]   rd_tag,
   output logic               rd_hit,
   input  logic               wr_en,
   input  logic [INDEX_W-1:0] wr_index,
   input  logic [TAG_W-1:0]   wr_tag
);

   localparam int LINES = 1 << INDEX_W;

   logic [TAG_W-1:0] tag_q [LINES];
   logic [LINES-1:0] valid_q;

   // Tags need no reset: a line is only trusted once its valid bit is set.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         tag_q[wr_index] <= wr_tag;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= '0;
      end else if (wr_en) begin
         valid_q[wr_index] <= 1'b1;
      end
   end

   assign rd_hit = valid_q[rd_index] && (tag_q[rd_index] == rd_tag);

endmodule

// File: rtl/dcache_controller.sv
// Sequencing FSM for a direct-mapped, write-through, no-write-allocate data cache.
//
//  state     | meaning
//  ----------+--------------------------------------------------------------
//  IDLE      | serve load hits; detect load miss or store and latch req_addr
//  READ_MISS | fetch the whole line word by word, writing each into the array
//  WRITE_MEM | write the store through to memory, core stalled until ack
module dcache_controller
   import dcache_pkg::*;
#(
   parameter int ADDR_W   = DC_ADDR_W,
   parameter int INDEX_W  = DC_INDEX_W,
   parameter int OFFSET_W = DC_OFFSET_W
) (
   input  logic             clk,
   input  logic             rst_n,
   dcache_controller_if.slave bus
);

   localparam int TAG_W = ADDR_W - INDEX_W - OFFSET_W;

   dc_state_t           state;
   logic [OFFSET_W-1:0] fill_cnt;
   logic [ADDR_W-1:0]   req_addr;

   logic [TAG_W-1:0]    cpu_tag;
   logic [INDEX_W-1:0]  cpu_index;
   logic [OFFSET_W-1:0] cpu_offset;
   logic [TAG_W-1:0]    req_tag;
   logic [INDEX_W-1:0]  req_index;
   logic [OFFSET_W-1:0] req_offset;

   logic                lookup_hit;
   logic                is_store;
   logic                is_load;
   logic                fill_last;
   logic                tag_we;

   assign cpu_tag    = bus.cpu_addr[ADDR_W-1:INDEX_W+OFFSET_W];
   assign cpu_index  = bus.cpu_addr[INDEX_W+OFFSET_W-1:OFFSET_W];
   assign cpu_offset = bus.cpu_addr[OFFSET_W-1:0];
   assign req_tag    = req_addr[ADDR_W-1:INDEX_W+OFFSET_W];
   assign req_index  = req_addr[INDEX_W+OFFSET_W-1:OFFSET_W];
   assign req_offset = req_addr[OFFSET_W-1:0];

   // A simultaneous read and write request is handled as a store.
   assign is_store  = bus.cpu_wr;
   assign is_load   = bus.cpu_rd && !bus.cpu_wr;
   assign fill_last = (fill_cnt == {OFFSET_W{1'b1}});
   assign tag_we    = (state == READ_MISS) && bus.mem_ack && fill_last;

   dcache_tag_store #(
      .INDEX_W (INDEX_W),
      .TAG_W   (TAG_W)
   ) u_tag_store (
      .clk      (clk),
      .rst_n    (rst_n),
      .rd_index (cpu_index),
      .rd_tag   (cpu_tag),
      .rd_hit   (lookup_hit),
      .wr_en    (tag_we),
      .wr_index (req_index),
      .wr_tag   (req_tag)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         fill_cnt <= '0;
         req_addr <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (is_store) begin
                  req_addr <= bus.cpu_addr;
                  state    <= WRITE_MEM;
               end else if (is_load && !lookup_hit) begin
                  req_addr <= bus.cpu_addr;
                  fill_cnt <= '0;
                  state    <= READ_MISS;
               end
            end
            READ_MISS: begin
               if (bus.mem_ack) begin
                  fill_cnt <= fill_cnt + 1'b1;
                  if (fill_last) begin
                     state <= IDLE;
                  end
               end
            end
            WRITE_MEM: begin
               if (bus.mem_ack) begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   logic stall_d;
   logic hit_d;
   logic arr_we_d;
   logic mem_req_d;

   always_comb begin
      stall_d        = 1'b0;
      hit_d          = 1'b0;
      arr_we_d       = 1'b0;
      mem_req_d      = 1'b0;
      bus.arr_src    = 1'b0;
      bus.mem_we     = 1'b0;
      bus.mem_addr   = req_addr;
      bus.arr_index  = req_index;
      bus.arr_offset = req_offset;
      case (state)
         IDLE: begin
            bus.arr_index  = cpu_index;
            bus.arr_offset = cpu_offset;
            hit_d          = is_load && lookup_hit;
            stall_d        = is_store || (is_load && !lookup_hit);
            arr_we_d       = is_store && lookup_hit;
         end
         READ_MISS: begin
            stall_d        = 1'b1;
            mem_req_d      = 1'b1;
            bus.mem_addr   = {req_addr[ADDR_W-1:OFFSET_W], fill_cnt};
            bus.arr_offset = fill_cnt;
            bus.arr_src    = 1'b1;
            arr_we_d       = bus.mem_ack;
         end
         WRITE_MEM: begin
            stall_d      = !bus.mem_ack;
            mem_req_d    = 1'b1;
            bus.mem_we   = 1'b1;
         end
         default: ;
      endcase
   end

   // Handshake outputs fall the instant reset is asserted, even while the core still requests.
   assign bus.stall   = stall_d   && rst_n;
   assign bus.hit     = hit_d     && rst_n;
   assign bus.arr_we  = arr_we_d  && rst_n;
   assign bus.mem_req = mem_req_d && rst_n;

endmodule

// File: tb/tb_dcache_controller.sv
// Self-checking bench for dcache_controller: directed scenarios plus randomized loads/stores vs. a line-level model.
module tb_dcache_controller;
   import dcache_pkg::*;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   dcache_controller_if bus ();

   dcache_controller dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int n_checks = 0;
   int n_errors = 0;

   // Reference model: what each line holds, nothing about how the FSM gets there.
   bit m_valid [16];
   int m_tag   [16];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got %0h exp %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic model_clear();
      for (int i = 0; i < 16; i++) begin
         m_valid[i] = 1'b0;
         m_tag[i]   = 0;
      end
   endtask

   function automatic bit model_hit(input logic [9:0] a);
      return m_valid[a[5:2]] && (m_tag[a[5:2]] == int'(a[9:6]));
   endfunction

   task automatic do_load(input logic [9:0] a, input int d);
      bit          exp_hit;
      int          stalls;
      logic [9:0]  ma;
      logic [31:0] wv;
      exp_hit = model_hit(a);
      stalls  = 0;
      bus.cpu_rd   = 1'b1;
      bus.cpu_wr   = 1'b0;
      bus.cpu_addr = a;
      @(negedge clk);
      check("ld_hit", bus.hit, exp_hit);
      check("ld_idle_req", bus.mem_req, 0);
      if (bus.stall) stalls++;
      if (!exp_hit) begin
         check("ld_miss_awe", bus.arr_we, 0);
         step();
         for (int w = 0; w < 4; w++) begin
            wv = w;
            ma = a;
            ma[1:0] = wv[1:0];
            for (int k = 0; k < d; k++) begin
               @(negedge clk);
               check("ld_wait_req", bus.mem_req, 1);
               check("ld_wait_addr", bus.mem_addr, ma);
               check("ld_wait_awe", bus.arr_we, 0);
               if (bus.stall) stalls++;
               step();
            end
            bus.mem_ack = 1'b1;
            @(negedge clk);
            check("ld_fill_req", bus.mem_req, 1);
            check("ld_fill_we", bus.mem_we, 0);
            check("ld_fill_addr", bus.mem_addr, ma);
            check("ld_fill_awe", bus.arr_we, 1);
            check("ld_fill_src", bus.arr_src, 1);
            check("ld_fill_off", bus.arr_offset, wv[1:0]);
            check("ld_fill_idx", bus.arr_index, a[5:2]);
            if (bus.stall) stalls++;
            step();
            bus.mem_ack = 1'b0;
         end
         m_valid[a[5:2]] = 1'b1;
         m_tag[a[5:2]]   = int'(a[9:6]);
         @(negedge clk);
         check("ld_after_fill_hit", bus.hit, 1);
         check("ld_after_fill_stall", bus.stall, 0);
         check("ld_after_fill_req", bus.mem_req, 0);
      end
      check("ld_stall_cycles", stalls, exp_hit ? 0 : 1 + 4 * (d + 1));
      step();
      bus.cpu_rd = 1'b0;
   endtask

   task automatic do_store(input logic [9:0] a, input int d, input bit both);
      bit exp_hit;
      int stalls;
      int we_cnt;
      exp_hit = model_hit(a);
      stalls  = 0;
      we_cnt  = 0;
      bus.cpu_rd   = both;
      bus.cpu_wr   = 1'b1;
      bus.cpu_addr = a;
      @(negedge clk);
      check("st_hit_out", bus.hit, 0);
      check("st_awe", bus.arr_we, exp_hit);
      check("st_idle_req", bus.mem_req, 0);
      if (exp_hit) begin
         check("st_src", bus.arr_src, 0);
         check("st_idx", bus.arr_index, a[5:2]);
         check("st_off", bus.arr_offset, a[1:0]);
      end
      if (bus.stall) stalls++;
      if (bus.arr_we) we_cnt++;
      step();
      for (int k = 0; k < d; k++) begin
         @(negedge clk);
         check("st_wait_req", bus.mem_req, 1);
         check("st_wait_we", bus.mem_we, 1);
         check("st_wait_addr", bus.mem_addr, a);
         if (bus.stall) stalls++;
         if (bus.arr_we) we_cnt++;
         step();
      end
      bus.mem_ack = 1'b1;
      @(negedge clk);
      check("st_ack_stall", bus.stall, 0);
      check("st_ack_req", bus.mem_req, 1);
      check("st_ack_we", bus.mem_we, 1);
      check("st_ack_addr", bus.mem_addr, a);
      if (bus.stall) stalls++;
      if (bus.arr_we) we_cnt++;
      step();
      bus.mem_ack = 1'b0;
      bus.cpu_wr  = 1'b0;
      bus.cpu_rd  = 1'b0;
      check("st_stall_cycles", stalls, 1 + d);
      check("st_awe_cycles", we_cnt, exp_hit ? 1 : 0);
   endtask

   task automatic idle_cycle(input bit spurious_ack);
      bus.cpu_rd  = 1'b0;
      bus.cpu_wr  = 1'b0;
      bus.mem_ack = spurious_ack;
      @(negedge clk);
      check("idle_req", bus.mem_req, 0);
      check("idle_stall", bus.stall, 0);
      check("idle_awe", bus.arr_we, 0);
      step();
      bus.mem_ack = 1'b0;
   endtask

   initial begin
      logic [9:0] ra;
      int         op;
      int         sel;
      bus.cpu_rd   = 1'b0;
      bus.cpu_wr   = 1'b0;
      bus.cpu_addr = '0;
      bus.mem_ack  = 1'b0;
      model_clear();

      repeat (2) @(posedge clk);
      #1;
      check("rst_req", bus.mem_req, 0);
      check("rst_stall", bus.stall, 0);
      check("rst_hit", bus.hit, 0);
      check("rst_awe", bus.arr_we, 0);
      rst_n = 1'b1;
      step();

      do_load(10'h0A5, 0);
      do_load(10'h0A6, 0);
      do_store(10'h0A5, 2, 1'b0);
      do_store(10'h0E5, 1, 1'b0);
      do_load(10'h0A5, 0);
      do_load(10'h0E5, 1);
      do_load(10'h0A5, 0);
      idle_cycle(1'b1);

      // Reset in the middle of a line fill after two words have been acknowledged.
      bus.cpu_rd   = 1'b1;
      bus.cpu_addr = 10'h135;
      @(negedge clk);
      check("mid_rst_miss", bus.stall, 1);
      step();
      for (int w = 0; w < 2; w++) begin
         bus.mem_ack = 1'b1;
         step();
      end
      bus.mem_ack = 1'b0;
      #2;
      check("mid_rst_pre_req", bus.mem_req, 1);
      rst_n = 1'b0;
      #1;
      check("mid_rst_req", bus.mem_req, 0);
      check("mid_rst_stall", bus.stall, 0);
      check("mid_rst_hit", bus.hit, 0);
      check("mid_rst_awe", bus.arr_we, 0);
      model_clear();
      step();
      rst_n = 1'b1;
      bus.cpu_rd = 1'b0;
      step();
      do_load(10'h135, 0);

      for (int n = 0; n < 120; n++) begin
         sel = $urandom_range(0, 3);
         ra  = 10'($urandom_range(0, 1023));
         ra[9:6] = 4'($urandom_range(0, 3));
         if (sel == 0) ra[5:2] = 4'd9;
         else if (sel == 1) ra[5:2] = 4'd13;
         op = $urandom_range(0, 9);
         if (op < 5) do_load(ra, $urandom_range(0, 2));
         else if (op < 8) do_store(ra, $urandom_range(0, 2), 1'b0);
         else if (op == 8) do_store(ra, $urandom_range(0, 2), 1'b1);
         else idle_cycle(1'($urandom_range(0, 1)));
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/dcache_controller.md
# dcache_controller

Sequencing FSM for the processor's direct-mapped, write-through, no-write-allocate data cache. It sits between the single-cycle core's load/store control signals and a word-wide main-memory port. It owns the tag/valid store and drives the external data array's write port. It stalls the core on read misses and on every store until main memory acknowledges.

## Interface
- `ADDR_W`, 10, word address width
- `INDEX_W`, 4, cache line index bits (16 lines)
- `OFFSET_W`, 2, word-in-line bits (4 words/line); tag width is `ADDR_W-INDEX_W-OFFSET_W`
- `clk` in 1: single clock, rising edge
- `rst_n` in 1: asynchronous, active-low reset
- `cpu_rd` in 1: load request (core MemRead)
- `cpu_wr` in 1: store request (core MemWrite)
- `cpu_addr` in ADDR_W: word address
- `stall` out 1: freeze core PC and pipeline state
- `hit` out 1: current load hits; data array output is valid
- `arr_we` out 1: data-array word write enable
- `arr_index` out INDEX_W: data-array line select
- `arr_offset` out OFFSET_W: data-array word select
- `arr_src` out 1: write data source, 0 = core store data, 1 = memory read data
- `mem_req` out 1: memory request, level-held until ack
- `mem_we` out 1: 1 = write, 0 = read
- `mem_addr` out ADDR_W: memory word address
- `mem_ack` in 1: one-cycle acknowledge; for reads it marks valid read data

## Operation
- Address split: tag = `cpu_addr[ADDR_W-1:INDEX_W+OFFSET_W]`, then index, then offset.
- States: IDLE, READ_MISS, WRITE_MEM.
- On entry to READ_MISS or WRITE_MEM, the address is latched into `req_addr`. The core holds its inputs while stalled, but the controller uses `req_addr` only.
- **IDLE, load hit** (valid[index] and tag match): `hit`=1, `stall`=0, no state change.
- **IDLE, load miss:** `stall`=1 combinationally. Next state is READ_MISS, with `fill_cnt`=0.
- **IDLE, store:** `stall`=1. On a hit, assert `arr_we`=1 and `arr_src`=0 at `cpu_addr` index/offset for exactly this cycle. On a miss, the array is untouched (no allocate). Next state is WRITE_MEM.
- `cpu_rd` and `cpu_wr` both high: treated as a store.
- **READ_MISS:**
  - Outputs: `mem_req`=1, `mem_we`=0, `mem_addr`={req tag, req index, `fill_cnt`}, `stall`=1.
  - On each `mem_ack`: `arr_we`=1, `arr_src`=1, `arr_offset`=`fill_cnt`, and `fill_cnt` increments (wraps at 2^OFFSET_W).
  - On the ack of the last word: tag[index] is written, valid[index] is set, and the next state is IDLE. The load then hits in IDLE.
- **WRITE_MEM:**
  - Outputs: `mem_req`=1, `mem_we`=1, `mem_addr`=`req_addr`.
  - `stall` is 1 until `mem_ack`. In the ack cycle `stall`=0, so the store retires, and the next state is IDLE.
- Outside READ_MISS and WRITE_MEM, `mem_req`=0.
- `arr_index` follows `cpu_addr` in IDLE and `req_addr` elsewhere.
- Reset, including mid-miss or mid-write:
  - State goes to IDLE; all valid bits and `fill_cnt` clear.
  - `mem_req`, `arr_we`, `stall` and `hit` drop immediately (asynchronously).
  - An aborted fill leaves its line invalid.

## Timing
- Load hit: 0 stall cycles; `hit` is combinational from `cpu_addr` and the tag store.
- Load miss with ack every cycle: 1 detect cycle + 4 fill cycles = 5 stall cycles, then the hit cycle.
- Store with immediate ack: 1 stall cycle; it retires in the WRITE_MEM ack cycle.
- `mem_addr` and `mem_we` are stable while `mem_req`=1 and no ack; they change only after an ack edge.
- `mem_ack` outside READ_MISS and WRITE_MEM is ignored.
- Tag/valid updates are registered. A line filled in cycle N hits from cycle N+1.

## Structure
- Package `dcache_pkg`: state encoding localparams (IDLE=2'd0, READ_MISS=2'd1, WRITE_MEM=2'd2) and the default widths plus the derived `TAG_W` and `LINES`.
- Sub-module `dcache_tag_store`: 2^INDEX_W × (TAG_W+1) array with combinational tag compare, a synchronous tag/valid write, and an async clear of all valid bits on `rst_n`.
- The FSM, `fill_cnt`, `req_addr` and output decode live in `dcache_controller`.

## Test plan
1. Reset, then load 0x0A5 (tag 2, index 9, offset 1) with ack every cycle.
   - `mem_addr` goes 0x0A4, 0x0A5, 0x0A6, 0x0A7 with `arr_we` each cycle.
   - `stall` is high for 5 cycles, then `hit`=1.
2. Load 0x0A6 after scenario 1 → `hit`=1, `stall`=0, `mem_req`=0.
3. Store 0x0A5 (hit), ack delayed 3 cycles.
   - `arr_we`=1 with `arr_src`=0 for exactly one cycle.
   - `mem_we`=1 at 0x0A5, `stall` high 3 cycles, low in the ack cycle.
4. Store 0x0E5 (tag 3, index 9, miss) → `arr_we` never asserted; memory write to 0x0E5. A following load of 0x0A5 still hits.
5. Load 0x0E5 (conflict) → refill 0x0E4–0x0E7 replaces line 9; a following load of 0x0A5 misses.
6. Assert `rst_n`=0 after the second fill ack of a miss → `mem_req` and `stall` drop asynchronously. After release, a load of the same address misses and starts at offset 0.
